// File: rtl/ysyx_23060180_pkg.sv
// Shared definitions for the SRAM responder: address map, write-size codes,
// byte-lane decode and the read-beat record carried down the read pipeline.
package ysyx_23060180_pkg;

  localparam logic [31:0] MEM_BASE  = 32'h8000_0000;

  localparam logic [3:0]  WBIT_BYTE = 4'd1;
  localparam logic [3:0]  WBIT_HALF = 4'd2;
  localparam logic [3:0]  WBIT_WORD = 4'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rd_beat_t;

  // Byte-enable mask for a right-aligned store of the given size at lane off.
  function automatic logic [3:0] lane_mask(input logic [3:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      WBIT_BYTE: m = 4'b0001 << off;
      WBIT_HALF: m = 4'b0011 << off;
      WBIT_WORD: m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

  // True when the size code is legal and the offset is naturally aligned for it.
  function automatic logic size_aligned(input logic [3:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      WBIT_BYTE: ok = 1'b1;
      WBIT_HALF: ok = ~off[0];
      WBIT_WORD: ok = (off == 2'd0);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_23060180_rd_pipe.sv
// Delay line for read beats: STAGES registers of {valid, data}; only the
// valid bits are reset so in-flight reads vanish on reset.
module ysyx_23060180_rd_pipe
  import ysyx_23060180_pkg::*;
#(
  parameter int STAGES = 0
) (
  input  logic     clk,
  input  logic     rstn_in,
  input  rd_beat_t beat_in,
  output rd_beat_t beat_out
);

  generate
    if (STAGES == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rstn_in;
      assign beat_out = beat_in;
    end else begin : g_regs
      logic [STAGES-1:0] vld_p;
      logic [31:0]       data_p [STAGES];

      always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= beat_in.valid;
          for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      always_ff @(posedge clk) begin
        data_p[0] <= beat_in.data;
        for (int i = 1; i < STAGES; i++) data_p[i] <= data_p[i-1];
      end

      assign beat_out = '{valid: vld_p[STAGES-1], data: data_p[STAGES-1]};
    end
  endgenerate

endmodule

// File: rtl/ysyx_23060180_sram_resp.sv
// Word-organised SRAM responder for the core memory port: sub-word steering,
// write-first bypass, configurable read latency and sticky error capture.
module ysyx_23060180_sram_resp
  import ysyx_23060180_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = MEM_BASE,
  parameter int          DEPTH_WORDS = 16384,
  parameter int          RD_LATENCY  = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rstn_in,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_raddr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wbit_en,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0] mem [DEPTH_WORDS];

  logic             hit;
  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic [3:0]       wmask;
  logic             wr_ok;
  logic             req_err;
  logic [31:0]      wdata_sh;
  logic [31:0]      merged;
  rd_beat_t         beat_p0;
  rd_beat_t         beat_out;

  assign off      = mem_raddr[1:0];
  assign hit      = (mem_raddr >= ADDR_BASE) && ({1'b0, mem_raddr} < ADDR_END);
  assign idx      = IDX_W'((mem_raddr - ADDR_BASE) >> 2);
  assign wmask    = lane_mask(mem_wbit_en, off);
  assign wr_ok    = mem_wr && hit && size_aligned(mem_wbit_en, off);
  assign req_err  = (mem_wr && !wr_ok) || (mem_rd && !hit);
  assign wdata_sh = mem_wdata << {off, 3'b000};

  // Read and write share one address, so a same-edge read always sees the merged word.
  always_comb begin
    merged = mem[idx];
    if (wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) merged[8*b +: 8] = wdata_sh[8*b +: 8];
      end
    end
  end

  assign beat_p0.valid = mem_rd;
  assign beat_p0.data  = hit ? (merged >> {off, 3'b000}) : 32'h0;

  always_ff @(posedge clk) begin
    if (rstn_in && wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // ---- extra latency stages ----
  ysyx_23060180_rd_pipe #(
    .STAGES (RD_LATENCY - 1)
  ) u_rd_pipe (
    .clk      (clk),
    .rstn_in  (rstn_in),
    .beat_in  (beat_p0),
    .beat_out (beat_out)
  );

  // ---- output register ----
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= 32'h0;
    end else begin
      mem_rvalid <= beat_out.valid;
      if (beat_out.valid) mem_rdata <= beat_out.data;
    end
  end

  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      bus_err  <= 1'b0;
      err_addr <= 32'h0;
    end else if (req_err && !bus_err) begin
      bus_err  <= 1'b1;
      err_addr <= mem_raddr;
    end
  end

endmodule

// File: tb/tb_ysyx_23060180_sram_resp.sv
// Directed bench: a latency-1 and a latency-3 responder share one stimulus
// stream; table vectors cover the single-cycle behaviour, sequences the rest.
module tb_ysyx_23060180_sram_resp;

  logic        clk = 1'b0;
  logic        rstn_in;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_raddr, mem_wdata;
  logic [3:0]  mem_wbit_en;

  logic [31:0] rdata1, eaddr1, rdata3, eaddr3;
  logic        rvalid1, err1, rvalid3, err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060180_sram_resp #(.RD_LATENCY(1)) u1 (
    .clk(clk), .rstn_in(rstn_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_raddr(mem_raddr), .mem_wdata(mem_wdata), .mem_wbit_en(mem_wbit_en),
    .mem_rdata(rdata1), .mem_rvalid(rvalid1), .bus_err(err1), .err_addr(eaddr1)
  );

  ysyx_23060180_sram_resp #(.RD_LATENCY(3)) u3 (
    .clk(clk), .rstn_in(rstn_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_raddr(mem_raddr), .mem_wdata(mem_wdata), .mem_wbit_en(mem_wbit_en),
    .mem_rdata(rdata3), .mem_rvalid(rvalid3), .bus_err(err3), .err_addr(eaddr3)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wbit;
    logic [31:0] exp_rdata;
    logic        exp_rvalid;
    logic        exp_err;
    logic [31:0] exp_eaddr;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    mem_rd = rd; mem_wr = wr; mem_raddr = a; mem_wdata = d; mem_wbit_en = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vals [4];

  initial begin
    //           rd    wr    addr          wdata         sz    rdata         rv    err   eaddr
    vecs[0]  = '{1'b0, 1'b1, 32'h80000010, 32'hDEADBEEF, 4'd4, 32'h00000000, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h80000010, 32'h0,        4'd0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h80000010, 32'hFFFFFFFF, 4'd4, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h80000013, 32'h000000A5, 4'd1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h80000010, 32'h0,        4'd0, 32'hA5FFFFFF, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h80000013, 32'h0,        4'd0, 32'h000000A5, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h80000012, 32'h0,        4'd0, 32'h0000A5FF, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'h80000011, 32'h00001234, 4'd2, 32'h0000A5FF, 1'b0, 1'b1, 32'h80000011};
    vecs[8]  = '{1'b1, 1'b0, 32'h80000010, 32'h0,        4'd0, 32'hA5FFFFFF, 1'b1, 1'b1, 32'h80000011};
    vecs[9]  = '{1'b1, 1'b0, 32'h00000000, 32'h0,        4'd0, 32'h00000000, 1'b1, 1'b1, 32'h80000011};
    vecs[10] = '{1'b1, 1'b1, 32'h80000020, 32'h12345678, 4'd4, 32'h12345678, 1'b1, 1'b1, 32'h80000011};
    vecs[11] = '{1'b0, 1'b1, 32'h80000022, 32'h0000BEEF, 4'd2, 32'h12345678, 1'b0, 1'b1, 32'h80000011};
    vecs[12] = '{1'b1, 1'b0, 32'h80000020, 32'h0,        4'd0, 32'hBEEF5678, 1'b1, 1'b1, 32'h80000011};
    vecs[13] = '{1'b0, 1'b1, 32'h80000020, 32'h00000000, 4'd3, 32'hBEEF5678, 1'b0, 1'b1, 32'h80000011};
    vecs[14] = '{1'b0, 1'b1, 32'h80010000, 32'h00000000, 4'd1, 32'hBEEF5678, 1'b0, 1'b1, 32'h80000011};
    vecs[15] = '{1'b1, 1'b0, 32'h80000020, 32'h0,        4'd0, 32'hBEEF5678, 1'b1, 1'b1, 32'h80000011};
    vecs[16] = '{1'b0, 1'b1, 32'h8000FFFC, 32'hCAFEF00D, 4'd4, 32'hBEEF5678, 1'b0, 1'b1, 32'h80000011};
    vecs[17] = '{1'b1, 1'b0, 32'h8000FFFE, 32'h0,        4'd0, 32'h0000CAFE, 1'b1, 1'b1, 32'h80000011};
    vecs[18] = '{1'b1, 1'b1, 32'h80000021, 32'h00000077, 4'd1, 32'h00BEEF77, 1'b1, 1'b1, 32'h80000011};
    vecs[19] = '{1'b0, 1'b0, 32'h80000020, 32'h0,        4'd0, 32'h00BEEF77, 1'b0, 1'b1, 32'h80000011};
    vecs[20] = '{1'b1, 1'b0, 32'h7FFFFFFC, 32'h0,        4'd0, 32'h00000000, 1'b1, 1'b1, 32'h80000011};
    vecs[21] = '{1'b1, 1'b0, 32'h80000020, 32'h0,        4'd0, 32'hBEEF7778, 1'b1, 1'b1, 32'h80000011};
    vecs[22] = '{1'b1, 1'b0, 32'h80010000, 32'h0,        4'd0, 32'h00000000, 1'b1, 1'b1, 32'h80000011};
    vals = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    rstn_in = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    step(); step();
    chk("reset rdata", rdata1, 32'h0);
    chk("reset rvalid", {31'h0, rvalid1}, 32'h0);
    chk("reset bus_err", {31'h0, err1}, 32'h0);
    chk("reset err_addr", eaddr1, 32'h0);
    rstn_in = 1'b1;
    step();

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wbit);
      step();
      chk($sformatf("v%0d rdata", i), rdata1, vecs[i].exp_rdata);
      chk($sformatf("v%0d rvalid", i), {31'h0, rvalid1}, {31'h0, vecs[i].exp_rvalid});
      chk($sformatf("v%0d bus_err", i), {31'h0, err1}, {31'h0, vecs[i].exp_err});
      chk($sformatf("v%0d err_addr", i), eaddr1, vecs[i].exp_eaddr);
    end

    // Latency-3 pipelining: four back-to-back reads.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 32'h80000000 + 32'(4 * k), vals[k], 4'd4);
      step();
    end
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drive(1'b1, 1'b0, 32'h80000000 + 32'(4 * k), 32'h0, 4'd0);
      else       drive(1'b0, 1'b0, 32'h80000000, 32'h0, 4'd0);
      step();
      chk($sformatf("lat1 rvalid e%0d", k), {31'h0, rvalid1}, {31'h0, (k < 4)});
      if (k < 4) chk($sformatf("lat1 rdata e%0d", k), rdata1, vals[k]);
      chk($sformatf("lat3 rvalid e%0d", k), {31'h0, rvalid3}, {31'h0, (k >= 2 && k <= 5)});
      if (k >= 2 && k <= 5) chk($sformatf("lat3 rdata e%0d", k), rdata3, vals[k-2]);
    end
    chk("lat3 rdata hold", rdata3, vals[3]);

    // Reset one cycle after an in-flight latency-3 read.
    drive(1'b1, 1'b0, 32'h80000004, 32'h0, 4'd0);
    step();
    drive(1'b0, 1'b0, 32'h80000000, 32'h0, 4'd0);
    step();
    rstn_in = 1'b0;
    #1;
    chk("rst async rvalid3", {31'h0, rvalid3}, 32'h0);
    chk("rst async rdata3", rdata3, 32'h0);
    chk("rst async bus_err", {31'h0, err1}, 32'h0);
    chk("rst async err_addr", eaddr1, 32'h0);
    drive(1'b0, 1'b1, 32'h80000000, 32'hBAD0BAD0, 4'd4);
    step();
    chk("rst flight rvalid3", {31'h0, rvalid3}, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h80000000, 32'h0, 4'd0);
    rstn_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post-rst rvalid3 c%0d", k), {31'h0, rvalid3}, 32'h0);
      chk($sformatf("post-rst rvalid1 c%0d", k), {31'h0, rvalid1}, 32'h0);
    end
    chk("post-rst rdata3", rdata3, 32'h0);
    chk("post-rst rdata1", rdata1, 32'h0);
    chk("post-rst bus_err3", {31'h0, err3}, 32'h0);
    chk("post-rst err_addr3", eaddr3, 32'h0);

    // The write issued under reset must not have landed.
    drive(1'b1, 1'b0, 32'h80000000, 32'h0, 4'd0);
    step();
    drive(1'b0, 1'b0, 32'h80000000, 32'h0, 4'd0);
    chk("rst-write rdata1", rdata1, vals[0]);
    chk("rst-write rvalid1", {31'h0, rvalid1}, 32'h1);
    step();
    step();
    chk("rst-write rdata3", rdata3, vals[0]);
    chk("rst-write rvalid3", {31'h0, rvalid3}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
